// File: rtl/music_sequencer.sv
// Note-ROM playback controller: steps the ROM address at a fixed tempo,
// latches note codes, strobes on onsets and detects end-of-song.
module music_sequencer #(
    parameter int unsigned TICK_DIV  = 6_000_000,
    parameter int unsigned END_ZEROS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_note,
    output logic [7:0] note_out,
    output logic       note_stb,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned ZW = $clog2(END_ZEROS + 1);
    // HOLD spans TICK_DIV-2 unpaused edges; the counter runs down to 0 inclusive.
    localparam logic [CW-1:0] HOLD_LOAD = CW'(TICK_DIV - 3);
    localparam logic [ZW-1:0] ZERO_LAST = ZW'(END_ZEROS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    note_q, note_d;
    logic [7:0]    prev_q, prev_d;
    logic          stb_q, stb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          loop_q, loop_d;
    logic [ZW-1:0] zcnt_q, zcnt_d;
    logic [CW-1:0] step_q, step_d;
    logic          end_song;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 8'd0;
            note_q  <= 8'd0;
            prev_q  <= 8'd0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            loop_q  <= 1'b0;
            zcnt_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            prev_q  <= prev_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            loop_q  <= loop_d;
            zcnt_q  <= zcnt_d;
            step_q  <= step_d;
        end
    end

    // Next-state and next-output logic; stop overrides everything else.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        note_d   = note_q;
        prev_d   = prev_q;
        stb_d    = 1'b0;
        done_d   = 1'b0;
        loop_d   = loop_q;
        zcnt_d   = zcnt_q;
        step_d   = step_q;
        end_song = 1'b0;

        case (state_q)
            S_IDLE: begin
                addr_d = 8'd0;
                note_d = 8'd0;
                if (play && !stop) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (rom_note != 8'd0) begin
                    // prev is cleared on rests, so a note after a rest always strobes
                    note_d  = rom_note;
                    stb_d   = (rom_note != prev_q);
                    prev_d  = rom_note;
                    zcnt_d  = '0;
                    step_d  = HOLD_LOAD;
                    state_d = S_HOLD;
                end else if (zcnt_q != ZERO_LAST) begin
                    note_d  = 8'd0;
                    prev_d  = 8'd0;
                    zcnt_d  = zcnt_q + ZW'(1);
                    step_d  = HOLD_LOAD;
                    state_d = S_HOLD;
                end else begin
                    end_song = 1'b1;
                end
            end
            S_HOLD: begin
                if (pause) begin
                    note_d = 8'd0;
                end else begin
                    note_d = prev_q;
                    if (step_q == '0) begin
                        if (addr_q != 8'hFF) begin
                            addr_d  = addr_q + 8'd1;
                            state_d = S_ADDR;
                        end else begin
                            end_song = 1'b1;
                        end
                    end else begin
                        step_d = step_q - CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = loop_q ? S_ADDR : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (end_song) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            note_d  = 8'd0;
            prev_d  = 8'd0;
            zcnt_d  = '0;
            addr_d  = 8'd0;
            loop_d  = loop;
        end

        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            addr_d  = 8'd0;
            note_d  = 8'd0;
            prev_d  = 8'd0;
            zcnt_d  = '0;
            stb_d   = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign rom_addr = addr_q;
    assign note_out = note_q;
    assign note_stb = stb_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer with a registered note ROM model.
module tb_music_sequencer;

    localparam int TD = 4;
    localparam int EZ = 2;
    localparam int LAST_REST = 241;

    typedef struct {
        int         at;
        logic [7:0] note;
        logic       is_done;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       play  = 1'b0;
    logic       stop  = 1'b0;
    logic       pause = 1'b0;
    logic       loop  = 1'b0;
    logic [7:0] rom_addr;
    logic [7:0] rom_note;
    logic [7:0] note_out;
    logic       note_stb;
    logic       busy;
    logic       done;

    logic [7:0] rom [256];
    int         cyc    = 0;
    int         n_chk  = 0;
    int         n_fail = 0;
    ev_t        exp_q[$];

    music_sequencer #(.TICK_DIV(TD), .END_ZEROS(EZ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .play     (play),
        .stop     (stop),
        .pause    (pause),
        .loop     (loop),
        .rom_addr (rom_addr),
        .rom_note (rom_note),
        .note_out (note_out),
        .note_stb (note_stb),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle registered ROM read.
    always @(posedge clk) rom_note <= rom[rom_addr];

    function automatic void load_song();
        for (int n = 0; n < 256; n++) begin
            if (n > 0 && (n % 9) == 0) rom[n] = rom[n-1];
            else                       rom[n] = 8'(20 + (n * 7) % 13);
        end
        rom[0] = 8'd25; rom[1] = 8'd27; rom[2] = 8'd27;
        rom[5] = 8'd0;  rom[100] = 8'd0;
        rom[LAST_REST] = 8'd0; rom[LAST_REST+1] = 8'd0;
    endfunction

    function automatic void load_no_end();
        for (int n = 0; n < 256; n++) rom[n] = 8'(60 + n / 4);
    endfunction

    // Expected onset strobes and done pulse from the ROM contents and step timing.
    function automatic void build_expected(input bit lp, output int end_at);
        logic [7:0] prev;
        logic [7:0] code;
        int         zc;
        bit         ended;
        ev_t        ev;
        prev = 8'd0; zc = 0; ended = 1'b0; end_at = TD * 256;
        for (int n = 0; n < 256 && !ended; n++) begin
            code = rom[n];
            if (code != 8'd0) begin
                if (code != prev) begin
                    ev.at = TD * n + 2; ev.note = code; ev.is_done = 1'b0;
                    exp_q.push_back(ev);
                end
                prev = code; zc = 0;
            end else begin
                zc++; prev = 8'd0;
                if (zc == EZ) begin ended = 1'b1; end_at = TD * n + 2; end
            end
        end
        ev.at = end_at; ev.note = 8'd0; ev.is_done = 1'b1;
        exp_q.push_back(ev);
        if (lp && rom[0] != 8'd0) begin
            ev.at = end_at + 3; ev.note = rom[0]; ev.is_done = 1'b0;
            exp_q.push_back(ev);
        end
    endfunction

    // Pulse play so that the next rising edge is edge 0; returns after edge 0.
    task automatic start_play(output int base);
        @(negedge clk);
        play = 1'b1;
        base = cyc + 1;
        @(negedge clk);
        play = 1'b0;
    endtask

    task automatic wait_to(input int base, input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic stop_pulse();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        #1 rst_n = 1'b0;
        #12;
        n_chk++;
        if ({rom_addr, note_out, note_stb, busy, done} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_init got addr=%0d note=%0d stb=%0b busy=%0b done=%0b want all 0",
                     rom_addr, note_out, note_stb, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        load_song();
        start_play(base);
        wait_to(base, 3);
        n_chk++;
        if (busy !== 1'b1 || note_out !== 8'd25) begin
            n_fail++;
            $display("FAIL reset_prehold got busy=%0b note=%0d want 1/25", busy, note_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({rom_addr, note_out, note_stb, busy, done} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_async got addr=%0d note=%0d stb=%0b busy=%0b done=%0b want all 0",
                     rom_addr, note_out, note_stb, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b0 || note_stb !== 1'b0 || rom_addr !== 8'd0 || note_out !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_quiet got busy=%0b stb=%0b addr=%0d note=%0d want idle",
                         busy, note_stb, rom_addr, note_out);
            end
        end
    endtask

    task automatic test_song(input bit lp);
        int  base;
        int  end_at;
        ev_t ev;
        load_song();
        loop = lp;
        exp_q.delete();
        build_expected(lp, end_at);
        start_play(base);
        for (int e = 0; e <= end_at + 4; e++) begin
            wait_to(base, e);
            if (note_stb || done) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL song_unexpected edge=%0d note=%0d done=%0b want no event", e, note_out, done);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.at !== e || ev.note !== note_out || ev.is_done !== done) begin
                        n_fail++;
                        $display("FAIL song_event got edge=%0d note=%0d done=%0b want edge=%0d note=%0d done=%0b",
                                 e, note_out, done, ev.at, ev.note, ev.is_done);
                    end
                end
            end
            if (e == TD * LAST_REST + 2) begin
                n_chk++;
                if (note_out !== 8'd0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL song_rest got note=%0d busy=%0b want 0/1", note_out, busy);
                end
            end
            if (e == end_at) begin
                n_chk++;
                if (done !== 1'b1 || rom_addr !== 8'd0 || note_out !== 8'd0) begin
                    n_fail++;
                    $display("FAIL song_done got done=%0b addr=%0d note=%0d want 1/0/0", done, rom_addr, note_out);
                end
            end
            if (e == end_at + 1) begin
                n_chk++;
                if (lp && (busy !== 1'b1 || rom_addr !== 8'd0 || done !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL loop_restart got busy=%0b addr=%0d done=%0b want 1/0/0", busy, rom_addr, done);
                end else if (!lp && (busy !== 1'b0 || done !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL song_idle got busy=%0b done=%0b want 0/0", busy, done);
                end
            end
            if (lp && e == end_at + 3) begin
                n_chk++;
                if (note_out !== 8'd25 || note_stb !== 1'b1) begin
                    n_fail++;
                    $display("FAIL loop_note got note=%0d stb=%0b want 25/1", note_out, note_stb);
                end
            end
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL song_missing got %0d pending events want 0", exp_q.size());
        end
        stop_pulse();
        loop = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pause();
        int  base;
        ev_t ev;
        load_song();
        exp_q.delete();
        ev.is_done = 1'b0;
        ev.at = 2; ev.note = 8'd25; exp_q.push_back(ev);
        ev.at = 6; ev.note = 8'd27; exp_q.push_back(ev);
        start_play(base);
        for (int e = 0; e <= 21; e++) begin
            wait_to(base, e);
            if (e == 6)  pause = 1'b1;
            if (e == 16) pause = 1'b0;
            if (note_stb || done) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pause_unexpected edge=%0d note=%0d done=%0b want no event", e, note_out, done);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.at !== e || ev.note !== note_out || ev.is_done !== done) begin
                        n_fail++;
                        $display("FAIL pause_event got edge=%0d note=%0d want edge=%0d note=%0d",
                                 e, note_out, ev.at, ev.note);
                    end
                end
            end
            if (e >= 7 && e <= 16) begin
                n_chk++;
                if (note_out !== 8'd0 || rom_addr !== 8'd1) begin
                    n_fail++;
                    $display("FAIL pause_mute edge=%0d got note=%0d addr=%0d want 0/1", e, note_out, rom_addr);
                end
            end
            if (e == 17) begin
                n_chk++;
                if (note_out !== 8'd27 || rom_addr !== 8'd1) begin
                    n_fail++;
                    $display("FAIL pause_restore got note=%0d addr=%0d want 27/1", note_out, rom_addr);
                end
            end
            if (e == 18) begin
                n_chk++;
                if (rom_addr !== 8'd2) begin
                    n_fail++;
                    $display("FAIL pause_step2 got addr=%0d want 2", rom_addr);
                end
            end
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pause_missing got %0d pending events want 0", exp_q.size());
        end
        stop_pulse();
        @(negedge clk);
    endtask

    task automatic test_stop();
        int  base;
        ev_t ev;
        load_song();
        exp_q.delete();
        ev.is_done = 1'b0;
        ev.at = 2; ev.note = 8'd25; exp_q.push_back(ev);
        ev.at = 6; ev.note = 8'd27; exp_q.push_back(ev);
        start_play(base);
        for (int e = 0; e <= 19; e++) begin
            wait_to(base, e);
            if (e == 13) stop = 1'b1;
            if (e == 14) play = 1'b1;
            if (e == 18) begin play = 1'b0; stop = 1'b0; end
            if (note_stb || done) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stop_unexpected edge=%0d note=%0d done=%0b want no event", e, note_out, done);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.at !== e || ev.note !== note_out || ev.is_done !== done) begin
                        n_fail++;
                        $display("FAIL stop_event got edge=%0d note=%0d want edge=%0d note=%0d",
                                 e, note_out, ev.at, ev.note);
                    end
                end
            end
            if (e == 13) begin
                n_chk++;
                if (busy !== 1'b1 || rom_addr !== 8'd3) begin
                    n_fail++;
                    $display("FAIL stop_predata got busy=%0b addr=%0d want 1/3", busy, rom_addr);
                end
            end
            if (e >= 14) begin
                n_chk++;
                if (busy !== 1'b0 || rom_addr !== 8'd0 || note_out !== 8'd0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stop_idle edge=%0d got busy=%0b addr=%0d note=%0d done=%0b want 0/0/0/0",
                             e, busy, rom_addr, note_out, done);
                end
            end
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stop_missing got %0d pending events want 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int  base;
        int  end_at;
        ev_t ev;
        load_no_end();
        exp_q.delete();
        build_expected(1'b0, end_at);
        start_play(base);
        for (int e = 0; e <= end_at + 2; e++) begin
            wait_to(base, e);
            if (note_stb || done) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wrap_unexpected edge=%0d note=%0d done=%0b want no event", e, note_out, done);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.at !== e || ev.note !== note_out || ev.is_done !== done) begin
                        n_fail++;
                        $display("FAIL wrap_event got edge=%0d note=%0d done=%0b want edge=%0d note=%0d done=%0b",
                                 e, note_out, done, ev.at, ev.note, ev.is_done);
                    end
                end
            end
            if (e == TD * 255) begin
                n_chk++;
                if (rom_addr !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_addr255 got addr=%0d want 255", rom_addr);
                end
            end
            if (e == end_at + 1) begin
                n_chk++;
                if (busy !== 1'b0 || rom_addr !== 8'd0) begin
                    n_fail++;
                    $display("FAIL wrap_idle got busy=%0b addr=%0d want 0/0", busy, rom_addr);
                end
            end
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_missing got %0d pending events want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_song(1'b0);
        test_song(1'b1);
        test_pause();
        test_stop();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
# music_sequencer

Playback controller for the music note ROMs (8-bit address, 8-bit note code, one-cycle registered read, code 0 = rest/end). It steps the ROM address at a fixed tempo and detects end-of-song. It supports play, stop, pause and loop, and presents a held note code plus a note-onset strobe to the downstream tone generator. It sits between the board control inputs and the note ROM / tone generator pair.

## Interface
- `TICK_DIV`, default 6_000_000: clocks per ROM step (one step = one eighth note); legal range ≥ 4.
- `END_ZEROS`, default 2: consecutive zero codes that mark end-of-song; legal range ≥ 1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `play`  in  1  level; sampled only in IDLE; starts playback from address 0.
- `stop`  in  1  level; aborts playback from any state; priority over `play` and `pause`.
- `pause`  in  1  level; freezes the step counter in HOLD and mutes `note_out`.
- `loop`  in  1  sampled at end-of-song; 1 = restart at address 0 instead of ending.
- `rom_addr`  out  8  address to note ROM.
- `rom_note`  in  8  ROM data, valid one cycle after `rom_addr` is sampled by the ROM.
- `note_out`  out  8  current note code to tone generator; 0 = silence.
- `note_stb`  out  1  one-cycle pulse on note onset.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end-of-song (also pulses on loop restart).

## Operation
- States: IDLE, ADDR, DATA, HOLD, DONE.
- Reset (async, any time): state=IDLE, `rom_addr`=0, `note_out`=0, `note_stb`=0, `busy`=0, `done`=0, zero counter=0, step counter=0, previous-note register=0.
- IDLE: `rom_addr` held at 0. If `play`=1 and `stop`=0, go to ADDR. `play` held high after DONE restarts playback immediately.
- ADDR (1 cycle): `rom_addr` is stable; the ROM registers it at the closing edge. Go to DATA.
- DATA (1 cycle): `rom_note` is valid; evaluated at the closing edge:
  - Nonzero code: `note_out`←code, zero counter←0, go to HOLD. `note_stb`=1 for the next cycle if the code differs from the previous latched code or the previous step was a rest. Repeated identical codes sustain without a strobe.
  - Zero code with zero counter+1 < `END_ZEROS`: rest. `note_out`←0, previous-note register←0, zero counter increments, no strobe, go to HOLD.
  - Zero code with zero counter+1 = `END_ZEROS`: end-of-song. Go to DONE, `note_out`←0.
- HOLD: lasts `TICK_DIV`−2 unpaused cycles. Step counter decrements only while `pause`=0. While `pause`=1, `note_out` reads 0; the latched code is restored on release with no new strobe.
- HOLD exit:
  - `rom_addr`≠255: `rom_addr`←`rom_addr`+1, go to ADDR.
  - `rom_addr`=255: address wrap is treated as end-of-song; go to DONE.
- DONE (1 cycle): `done`=1, `note_out`=0, zero counter←0, `rom_addr`←0.
  - `loop`=1 (sampled at DONE entry edge): next state ADDR.
  - `loop`=0: next state IDLE.
- `stop`=1 in any non-IDLE state: at the next edge, state=IDLE, `rom_addr`=0, `note_out`=0, zero counter cleared, no `done` pulse. A `stop` that coincides with the end-of-song decision wins.
- `play` while `busy`=1 is ignored. `pause` in ADDR/DATA/DONE is ignored; the fetch completes and the freeze applies on HOLD entry.

## Timing
- Edge numbering: the edge that samples `play`=1 in IDLE is edge 0.
  - ADDR from edge 0, DATA from edge 1.
  - `note_out` valid and `note_stb` high after edge 2.
  - Play-to-note latency: 2 cycles.
- Step period: exactly `TICK_DIV` cycles when unpaused. Address n is presented from edge n·`TICK_DIV`; its note is latched at edge n·`TICK_DIV`+2.
- Pausing for P cycles inside HOLD lengthens that step by exactly P cycles.
- `note_stb` and `done` are registered single-cycle pulses, never back-to-back within one step.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset mid-HOLD: assert `rst_n`=0 asynchronously -> all outputs 0 immediately, state IDLE; after release, no activity until `play`.
- `TICK_DIV`=4, ROM loaded with the Rudolf table, `play` pulse at edge 0 -> `note_out`=25 with strobe after edge 2, `note_out`=27 with strobe after edge 6, and no strobe at edge 10 (27 repeats).
- Same run to completion, `loop`=0 -> address 241 yields `note_out`=0 (rest) after edge 966, DONE entered at edge 970, `done` high for one cycle, `busy`=0 from edge 971.
- Same run with `loop`=1 -> `done` pulse at edge 970, `rom_addr`=0 in ADDR at edge 971, `note_out`=25 with strobe after edge 973.
- `pause` high for 10 cycles during step 1's HOLD -> `note_out`=0 while paused, 27 restored with no strobe, and step 2 address presented at edge 18 instead of 8.
- `stop` asserted in DATA of step 3 -> IDLE next edge, `rom_addr`=0, `note_out`=0, no `done`. `play` and `stop` both high in IDLE -> stays IDLE.
